sequence_player: RTL and testbench
==================================

# sequence_player

Stores the growing colour sequence of the Simon game and plays it back on the four colour LEDs. Each round, on `i_start`, it sends a one-cycle trigger to the random-number generator and appends the returned value (1–4) to its sequence memory. It then replays the whole sequence with fixed on/off timing and pulses `o_play_done`. It sits directly downstream of the generator and upstream of the player-input checker, which reads stored elements through a read port.

## Interface
- `MAX_LEN`, 32: sequence capacity in elements (≥2).
- `ON_CYCLES`, 25_000_000: cycles each LED is lit during playback (≥1).
- `OFF_CYCLES`, 12_500_000: dark gap after each element (≥1).
- `GEN_TIMEOUT`, 16: cycles to wait for `i_gen_ready` before re-triggering (≥2).
- `i_clk` in 1: system clock; single clock domain.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_start` in 1: pulse that starts a round (append one element, then play).
- `i_clear` in 1: pulse that empties the sequence (new game).
- `o_gen_trigger` out 1: one-cycle generation request to the generator.
- `i_gen_ready` in 1: generator value valid.
- `i_gen_value` in 3: generated value, 1–4.
- `o_led` out 4: one-hot LED drive; bit n lights colour n+1.
- `o_busy` out 1: high in every state except IDLE.
- `o_play_done` out 1: one-cycle pulse when playback finishes.
- `o_full` out 1: length == MAX_LEN.
- `o_length` out clog2(MAX_LEN+1): number of stored elements.
- `i_rd_idx` in clog2(MAX_LEN): checker read index.
- `o_rd_value` out 3: stored value at `i_rd_idx` (1–4); 0 when `i_rd_idx` ≥ `o_length`. Combinational read.

## Operation
- **States:** IDLE, REQUEST, WAIT_GEN, PLAY_ON, PLAY_OFF, DONE.
- **IDLE, `i_start`, not full:** go to REQUEST.
- **IDLE, `i_start`, full:** skip generation, go to PLAY_ON with idx=0. This replays the stored sequence; length is unchanged.
- **REQUEST:** `o_gen_trigger`=1 for exactly this cycle. Clear the timeout counter and go to WAIT_GEN.
- **WAIT_GEN, `i_gen_ready`=1:**
  - Store the value at mem[length] and increment length.
  - Go to PLAY_ON with idx=0.
- **Value encoding:** the stored colour is `i_gen_value[1:0]` interpreted as 1,2,3 → colours 1,2,3 and 0 → colour 4. Therefore 4 and 0 both store 4, and any value >4 aliases by its low two bits.
- **WAIT_GEN timeout:** after GEN_TIMEOUT cycles without ready, return to REQUEST (re-trigger). There is no retry limit.
- **PLAY_ON:** `o_led` = one-hot(mem[idx]) for ON_CYCLES cycles, then go to PLAY_OFF.
- **PLAY_OFF:** `o_led`=0 for OFF_CYCLES cycles.
  - If idx == length−1, go to DONE.
  - Otherwise increment idx and go to PLAY_ON.
- **DONE:** `o_play_done`=1 for one cycle, then go to IDLE.
- **`i_gen_ready` outside WAIT_GEN:** ignored; no store.
- **`i_start` while busy:** ignored.
- **`i_clear` in IDLE:** length ← 0.
- **`i_clear` in any other state:** abort to IDLE next cycle. length ← 0, `o_led`=0, no `o_play_done`, and no store even if ready arrives on the same cycle.
- **`i_clear` and `i_start` in the same cycle:** clear wins; start is dropped.
- **Memory:** contents are not reset. Entries at index ≥ length are never visible on `o_rd_value` or `o_led`.

## Timing
- **Reset (`i_rst_n`=0 at an edge):** state IDLE, length 0, idx 0, all counters 0. All outputs are 0: `o_led`, `o_gen_trigger`, `o_busy`, `o_play_done`, `o_full`, `o_length`, `o_rd_value`. Reset mid-round aborts identically to clear.
- **Latency:** `i_start` sampled at edge 0 → `o_gen_trigger` high during cycle 1 and `o_busy` high from cycle 1. If `i_gen_ready` is sampled at edge k, then `o_length` updates and `o_led` lights from cycle k+1.
- **Playback length:** one element occupies exactly ON_CYCLES+OFF_CYCLES cycles. `o_play_done` rises one cycle after the last OFF period ends. `o_busy` falls the cycle after `o_play_done`.
- **Outputs:** `o_led`, `o_gen_trigger`, and `o_play_done` are registered. `o_full` and `o_length` are registered and update together.
- **Generator response:** a generator answering one cycle after the trigger (ready at edge 2) must be accepted with no lost value.

## Test plan
Run with ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=4, GEN_TIMEOUT=8.
- **First element:**
  - Stimulus: after reset, pulse `i_start`; generator returns 3 one cycle after the trigger.
  - Required: exactly one trigger pulse; `o_length`=1; `o_led`=4'b0100 for 4 cycles, then 0 for 2 cycles; then one `o_play_done` pulse; `o_rd_value`(idx 0)=3.
- **Growing sequence:**
  - Stimulus: returns 1, 4, 2 over three more rounds.
  - Required: playback order 0001, 1000, 0010 appended each round (last round plays 0100, 0001, 1000, 0010); `o_full`=1 after the 4th round. A 5th `i_start` produces no trigger and replays the 4 elements with length 4.
- **Timeout:**
  - Stimulus: withhold ready for 8 cycles after the trigger, then answer 2.
  - Required: a second trigger pulse exactly 8 cycles after WAIT_GEN entry; value 2 is stored once.
- **Abort:**
  - Stimulus: `i_clear` during PLAY_ON of element 2.
  - Required: `o_led`=0 and `o_busy`=0 next cycle; `o_length`=0; no `o_play_done`; `o_rd_value`=0 for all indices.
- **Collision:**
  - Stimulus: `i_clear` and `i_start` in the same IDLE cycle.
  - Required: no trigger; length 0.
  - Stimulus: spurious `i_gen_ready` with value 1 in IDLE.
  - Required: length unchanged.
- **Value 4 / alias and reset:**
  - Stimulus: generator returns 4 (and separately 0).
  - Required: `o_led`=4'b1000; `o_rd_value`=4.
  - Stimulus: assert `i_rst_n`=0 mid-WAIT_GEN.
  - Required: all outputs 0 after one edge.

Source files
------------

// File: rtl/sequence_player.sv
// sequence_player
//
// Holds the growing colour sequence for the Simon game and replays it on the
// four colour LEDs. Each round (i_start) asks the random generator for one new
// colour, appends it, then plays the whole sequence back with fixed on/off
// timing and pulses o_play_done. A combinational read port lets the
// player-input checker look at stored elements.
//
// Ports
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_start             pulse: start a round (append + play, or replay if full)
//   i_clear             pulse: empty the sequence, abort any round in progress
//   o_gen_trigger       one-cycle generation request to the generator
//   i_gen_ready         generator value valid
//   i_gen_value[2:0]    generated value, 1..4 (low two bits select the colour)
//   o_led[3:0]          one-hot LED drive, bit n lights colour n+1
//   o_busy              high whenever the FSM is not idle
//   o_play_done         one-cycle pulse after the last element's dark gap
//   o_full              length == MAX_LEN
//   o_length            number of stored elements
//   i_rd_idx            checker read index
//   o_rd_value[2:0]     colour at i_rd_idx (1..4), 0 when the index is unused
//
// Generator handshake: o_gen_trigger is a single-cycle request. The generator
// has no backpressure; i_gen_ready qualifies i_gen_value and is only honoured
// while waiting for an answer. If no answer arrives within GEN_TIMEOUT cycles
// the request is re-issued, indefinitely.

module sequence_player #(
    parameter int MAX_LEN     = 32,
    parameter int ON_CYCLES   = 25_000_000,
    parameter int OFF_CYCLES  = 12_500_000,
    parameter int GEN_TIMEOUT = 16,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int IW = $clog2(MAX_LEN)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_clear,
    output logic          o_gen_trigger,
    input  logic          i_gen_ready,
    input  logic [2:0]    i_gen_value,
    output logic [3:0]    o_led,
    output logic          o_busy,
    output logic          o_play_done,
    output logic          o_full,
    output logic [LW-1:0] o_length,
    input  logic [IW-1:0] i_rd_idx,
    output logic [2:0]    o_rd_value
);

    // One shared down-time/on-time/timeout counter; sized for the largest use.
    localparam int CNT_MAX_A = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > GEN_TIMEOUT) ? CNT_MAX_A : GEN_TIMEOUT;
    localparam int CW        = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQUEST  = 3'd1,
        S_WAIT_GEN = 3'd2,
        S_PLAY_ON  = 3'd3,
        S_PLAY_OFF = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t        state_q;
    logic [LW-1:0] length_q;
    logic          full_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    led_q;
    logic          trig_q;
    logic          done_q;

    // Sequence storage is deliberately not reset; length_q masks stale entries.
    logic [2:0]    mem_q [MAX_LEN];

    logic [2:0]    gen_colour;
    logic [IW-1:0] idx_d;
    logic          store_en;
    logic          gen_value_msb_unused;

    // Only the low two bits carry the colour: 1,2,3 map directly, 0 means 4.
    assign gen_colour           = (i_gen_value[1:0] == 2'b00) ? 3'd4 : {1'b0, i_gen_value[1:0]};
    assign gen_value_msb_unused = i_gen_value[2];
    assign idx_d                = idx_q + 1'b1;

    // A clear or reset on the same edge as ready suppresses the store.
    assign store_en = i_rst_n && !i_clear && (state_q == S_WAIT_GEN) && i_gen_ready;

    function automatic logic [3:0] colour_led(input logic [2:0] colour);
        case (colour)
            3'd1:    colour_led = 4'b0001;
            3'd2:    colour_led = 4'b0010;
            3'd3:    colour_led = 4'b0100;
            3'd4:    colour_led = 4'b1000;
            default: colour_led = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (store_en) begin
            mem_q[length_q[IW-1:0]] <= gen_colour;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            state_q  <= S_IDLE;
            length_q <= '0;
            full_q   <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            led_q    <= 4'b0000;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        if (full_q) begin
                            // Full: replay what is stored without a new element.
                            state_q <= S_PLAY_ON;
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            led_q   <= colour_led(mem_q[0]);
                        end else begin
                            state_q <= S_REQUEST;
                            trig_q  <= 1'b1;
                        end
                    end
                end
                S_REQUEST: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_GEN;
                end
                S_WAIT_GEN: begin
                    if (i_gen_ready) begin
                        length_q <= length_q + 1'b1;
                        full_q   <= (length_q == LW'(MAX_LEN - 1));
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        // The new value is not yet readable from mem_q, so an
                        // empty sequence shows it straight from the generator.
                        led_q    <= colour_led((length_q == '0) ? gen_colour : mem_q[0]);
                        state_q  <= S_PLAY_ON;
                    end else if (cnt_q == CW'(GEN_TIMEOUT - 1)) begin
                        state_q <= S_REQUEST;
                        trig_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PLAY_ON: begin
                    if (cnt_q == CW'(ON_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        led_q   <= 4'b0000;
                        state_q <= S_PLAY_OFF;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PLAY_OFF: begin
                    if (cnt_q == CW'(OFF_CYCLES - 1)) begin
                        cnt_q <= '0;
                        if (LW'(idx_q) == length_q - 1'b1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_d;
                            led_q   <= colour_led(mem_q[idx_d]);
                            state_q <= S_PLAY_ON;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gen_trigger = trig_q;
    assign o_led         = led_q;
    assign o_play_done   = done_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_full        = full_q;
    assign o_length      = length_q;
    assign o_rd_value    = (LW'(i_rd_idx) < length_q) ? mem_q[i_rd_idx] : 3'd0;

endmodule

// File: tb/tb_sequence_player.sv
// Testbench for sequence_player (MAX_LEN=4, ON=4, OFF=2, GEN_TIMEOUT=8).
// Reference model: the expected sequence is a queue of colours; the expected
// LED trace is expanded from it element by element.

module tb_sequence_player;

    localparam int MAX_LEN     = 4;
    localparam int ON_CYCLES   = 4;
    localparam int OFF_CYCLES  = 2;
    localparam int GEN_TIMEOUT = 8;
    localparam int LW          = $clog2(MAX_LEN + 1);
    localparam int IW          = $clog2(MAX_LEN);

    // ---------------- clock / reset / DUT ----------------
    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          clear     = 1'b0;
    logic          gen_ready = 1'b0;
    logic [2:0]    gen_value = 3'd0;
    logic [IW-1:0] rd_idx    = '0;
    logic          gen_trigger;
    logic [3:0]    led;
    logic          busy;
    logic          play_done;
    logic          full;
    logic [LW-1:0] length;
    logic [2:0]    rd_value;

    always #5 clk = ~clk;

    sequence_player #(
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON_CYCLES),
        .OFF_CYCLES (OFF_CYCLES),
        .GEN_TIMEOUT(GEN_TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_clear      (clear),
        .o_gen_trigger(gen_trigger),
        .i_gen_ready  (gen_ready),
        .i_gen_value  (gen_value),
        .o_led        (led),
        .o_busy       (busy),
        .o_play_done  (play_done),
        .o_full       (full),
        .o_length     (length),
        .i_rd_idx     (rd_idx),
        .o_rd_value   (rd_value)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         trig_seen = 0;
    int         done_seen = 0;
    int         model_q[$];
    logic [3:0] exp_q[$];

    typedef struct {
        int gen_val;
        int timeouts;
        int exp_colour;
        int exp_full;
    } vec_t;

    vec_t vecs[4];

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (gen_trigger === 1'b1) trig_seen++;
        if (play_done === 1'b1) done_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int colour_of(input int v);
        int r;
        r = v % 4;
        return (r == 0) ? 4 : r;
    endfunction

    function automatic logic [3:0] led_of(input int c);
        return 4'(1 << (c - 1));
    endfunction

    task automatic check_len(input string tag);
        check({tag, "_length"}, int'(length), model_q.size());
        check({tag, "_full"}, int'(full), (model_q.size() == MAX_LEN) ? 1 : 0);
    endtask

    task automatic check_rd(input string tag);
        for (int i = 0; i < MAX_LEN; i++) begin
            rd_idx = IW'(i);
            #1;
            check({tag, "_rd_value"}, int'(rd_value), (i < model_q.size()) ? model_q[i] : 0);
        end
        rd_idx = '0;
    endtask

    // Called in the first lit cycle; walks the whole expected trace.
    task automatic check_playback(input string tag);
        logic [3:0] e;
        exp_q.delete();
        foreach (model_q[i]) begin
            repeat (ON_CYCLES) exp_q.push_back(led_of(model_q[i]));
            repeat (OFF_CYCLES) exp_q.push_back(4'b0000);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_led"}, int'(led), int'(e));
            check({tag, "_done_early"}, int'(play_done), 0);
            tick();
        end
        check({tag, "_play_done"}, int'(play_done), 1);
        check({tag, "_busy_in_done"}, int'(busy), 1);
        tick();
        check({tag, "_done_width"}, int'(play_done), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic wait_trigger(input string tag, output int at);
        int n;
        n = 0;
        while (gen_trigger !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_trigger_seen"}, int'(gen_trigger === 1'b1), 1);
        at = cyc;
    endtask

    // Generator driver: ignores `timeouts` requests, answers the next one a
    // cycle later.
    task automatic gen_respond(input string tag, input int v, input int timeouts);
        int t0, t1;
        wait_trigger(tag, t0);
        for (int r = 0; r < timeouts; r++) begin
            tick();
            wait_trigger(tag, t1);
            check({tag, "_retrigger_gap"}, t1 - t0, GEN_TIMEOUT + 1);
            t0 = t1;
        end
        tick();
        gen_ready = 1'b1;
        gen_value = 3'(v);
        tick();
        gen_ready = 1'b0;
        gen_value = 3'd0;
    endtask

    task automatic run_round(input string tag, input int v, input int timeouts);
        int trig0;
        trig0 = trig_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_trig_latency"}, int'(gen_trigger), 1);
        check({tag, "_busy_latency"}, int'(busy), 1);
        gen_respond(tag, v, timeouts);
        model_q.push_back(colour_of(v));
        check_len(tag);
        check_playback(tag);
        check_rd(tag);
        check({tag, "_trig_count"}, trig_seen - trig0, 1 + timeouts);
    endtask

    task automatic run_replay(input string tag);
        int trig0;
        trig0 = trig_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        check_len(tag);
        check_playback(tag);
        check({tag, "_no_trigger"}, trig_seen - trig0, 0);
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_q.delete();
        check_len(tag);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int trig0, done0, r, len0;

        vecs[0] = '{3, 0, 3, 0};
        vecs[1] = '{1, 0, 1, 0};
        vecs[2] = '{4, 0, 4, 0};
        vecs[3] = '{2, 1, 2, 1};

        // Reset
        rst_n = 1'b0;
        tick();
        check("rst_led", int'(led), 0);
        check("rst_trigger", int'(gen_trigger), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(play_done), 0);
        check("rst_full", int'(full), 0);
        check("rst_length", int'(length), 0);
        check("rst_rd_value", int'(rd_value), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Growing sequence to full, last round exercises the timeout.
        for (int i = 0; i < 4; i++) begin
            run_round($sformatf("round%0d", i), vecs[i].gen_val, vecs[i].timeouts);
            rd_idx = IW'(i);
            #1;
            check("table_colour", int'(rd_value), vecs[i].exp_colour);
            rd_idx = '0;
            check("table_full", int'(full), vecs[i].exp_full);
        end

        // Full: replay without generation.
        run_replay("replay_full");
        check_rd("replay_full");

        do_clear("clear_idle");
        check_rd("clear_idle");

        // Abort during PLAY_ON of element 2.
        run_round("abort_a", 1, 0);
        done0 = done_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        gen_respond("abort_b", 2, 0);
        model_q.push_back(colour_of(2));
        repeat (ON_CYCLES + OFF_CYCLES) tick();
        check("abort_elem2_led", int'(led), int'(led_of(2)));
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_q.delete();
        check("abort_led", int'(led), 0);
        check("abort_busy", int'(busy), 0);
        check_len("abort");
        repeat (10) tick();
        check("abort_no_done", done_seen - done0, 0);
        check_rd("abort");

        // Clear and start together.
        run_round("coll_pre", 3, 0);
        trig0 = trig_seen;
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        model_q.delete();
        repeat (3) tick();
        check("coll_no_trigger", trig_seen - trig0, 0);
        check("coll_busy", int'(busy), 0);
        check_len("coll");

        // Spurious ready in IDLE.
        run_round("spur_pre", 2, 0);
        gen_ready = 1'b1;
        gen_value = 3'd1;
        tick();
        gen_ready = 1'b0;
        gen_value = 3'd0;
        tick();
        check_len("spurious");
        check("spurious_busy", int'(busy), 0);
        check_rd("spurious");

        // Value 0 aliases to colour 4.
        run_round("val0", 0, 0);
        rd_idx = IW'(model_q.size() - 1);
        #1;
        check("val0_rd_value", int'(rd_value), 4);
        rd_idx = '0;

        // Reset in WAIT_GEN.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("wait_busy", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        model_q.delete();
        check("rstw_led", int'(led), 0);
        check("rstw_trigger", int'(gen_trigger), 0);
        check("rstw_busy", int'(busy), 0);
        check("rstw_done", int'(play_done), 0);
        check("rstw_full", int'(full), 0);
        check("rstw_length", int'(length), 0);
        check("rstw_rd_value", int'(rd_value), 0);
        rst_n = 1'b1;
        tick();

        // Randomized rounds against the model.
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            repeat ($urandom_range(0, 3)) tick();
            if (r == 0) begin
                do_clear("rnd_clear");
            end else if (r == 1) begin
                len0 = model_q.size();
                gen_ready = 1'b1;
                gen_value = 3'($urandom_range(0, 7));
                tick();
                gen_ready = 1'b0;
                check("rnd_spurious_len", int'(length), len0);
            end else if (model_q.size() == MAX_LEN) begin
                if (r < 6) run_replay("rnd_replay");
                else do_clear("rnd_clear_full");
            end else begin
                run_round("rnd", int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 1 : 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
